// File: rtl/ad9226if.sv
// ad9226if: capture front end for a 12-bit parallel pipelined ADC (AD9226 class).
// Generates the converter sample clock from i_clk, registers the ADC bus on every
// rising edge of that clock, throws away the converter's pipeline-latency samples
// after a start request, then pushes a fixed-length block of two's-complement
// samples into a small first-word-fall-through FIFO with a valid/ready handshake.
//
// Optional build macro: AD9226IF_OTR_SAT_EN
//   defined   : samples flagged out-of-range are clamped to full scale before the FIFO
//   undefined : converted samples are written unchanged
// o_otr (sticky out-of-range flag) behaves the same in both builds.

module ad9226if #(
  parameter int CLK_DIV    = 4,   // i_clk cycles per half-period of o_adc_clk (2..15)
  parameter int PIPE_LAT   = 7,   // samples discarded after start (0..15)
  parameter int BLOCK_LEN  = 16,  // samples delivered per capture (1..4095)
  parameter int FIFO_DEPTH = 4    // output FIFO entries, power of two (2..16)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_adc_clk,
  input  logic [11:0] i_adc_data,
  input  logic        i_adc_otr,
  input  logic        i_start,
  output logic        o_busy,
  output logic [11:0] o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_last,
  output logic        o_overflow,
  output logic        o_otr
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [3:0]    DIV_LAST   = 4'(CLK_DIV - 1);
  localparam logic [3:0]    PIPE_LAST  = 4'(PIPE_LAT - 1);  // unused when PIPE_LAT == 0
  localparam logic [11:0]   BLOCK_LAST = 12'(BLOCK_LEN - 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam bit            PIPE_NONE  = (PIPE_LAT == 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_FILL  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Sample format helpers
  // ---------------------------------------------------------------------------
  // Offset binary to two's complement is a flip of the MSB.
  function automatic logic [11:0] f_to_twos(input logic [11:0] raw);
    return {~raw[11], raw[10:0]};
  endfunction

  // Full-scale clamp for an out-of-range sample; the raw MSB tells which rail.
  function automatic logic [11:0] f_saturate(input logic [11:0] raw);
    logic [11:0] v;
    if (raw[11]) begin
      v = 12'h7FF;
    end else begin
      v = 12'h800;
    end
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [3:0]    r_div_cnt;
  logic          r_adc_clk;
  logic          w_strobe;

  logic [11:0]   r_sample;
  logic          r_sample_otr;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_clr;
  logic          w_disc_inc;
  logic          w_capture;
  logic          w_cap_last;

  logic [3:0]    r_disc_cnt;
  logic [11:0]   r_samp_cnt;

  logic          r_wr_pend;
  logic          r_wr_last;
  logic [11:0]   w_wr_data;

  logic [11:0]   r_mem_data [FIFO_DEPTH];
  logic          r_mem_last [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          w_full;
  logic          w_pop;
  logic          w_wr_acc;
  logic          w_wr_drop;

  logic          r_overflow;
  logic          r_otr;

  // ---------------------------------------------------------------------------
  // Sample clock generation
  // ---------------------------------------------------------------------------
  // Free-running divider: toggle the ADC clock every CLK_DIV system clocks.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div_cnt <= 4'd0;
      r_adc_clk <= 1'b0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= 4'd0;
      r_adc_clk <= ~r_adc_clk;
    end else begin
      r_div_cnt <= r_div_cnt + 4'd1;
    end
  end

  // The strobe marks the edge that drives o_adc_clk high; the ADC bus is
  // captured on that same edge.
  assign w_strobe = (r_div_cnt == DIV_LAST) && !r_adc_clk;

  // Capture the ADC bus and its out-of-range bit on every strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sample     <= 12'd0;
      r_sample_otr <= 1'b0;
    end else if (w_strobe) begin
      r_sample     <= i_adc_data;
      r_sample_otr <= i_adc_otr;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture sequencer
  // ---------------------------------------------------------------------------
  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_disc_inc  = 1'b0;
    w_capture   = 1'b0;
    w_cap_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_clr       = 1'b1;
          w_state_nxt = PIPE_NONE ? S_FILL : S_FLUSH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (w_strobe) begin
          w_disc_inc = 1'b1;
          if (r_disc_cnt == PIPE_LAST) begin
            w_state_nxt = S_FILL;
          end else begin
            w_state_nxt = S_FLUSH;
          end
        end else begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FILL: begin
        if (w_strobe) begin
          w_capture  = 1'b1;
          w_cap_last = (r_samp_cnt == BLOCK_LAST);
          if (w_cap_last) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_FILL;
          end
        end else begin
          w_state_nxt = S_FILL;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Discard and sample counters; both restart on every accepted start.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_disc_cnt <= 4'd0;
      r_samp_cnt <= 12'd0;
    end else if (w_clr) begin
      r_disc_cnt <= 4'd0;
      r_samp_cnt <= 12'd0;
    end else begin
      if (w_disc_inc) begin
        r_disc_cnt <= r_disc_cnt + 4'd1;
      end
      if (w_capture) begin
        r_samp_cnt <= r_samp_cnt + 12'd1;
      end
    end
  end

  // A FILL capture becomes a FIFO write one cycle later, once r_sample holds it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_pend <= 1'b0;
      r_wr_last <= 1'b0;
    end else begin
      r_wr_pend <= w_capture;
      r_wr_last <= w_cap_last;
    end
  end

  // Sticky out-of-range flag for samples taken during FILL.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_otr <= 1'b0;
    end else if (w_clr) begin
      r_otr <= 1'b0;
    end else if (w_capture && i_adc_otr) begin
      r_otr <= 1'b1;
    end
  end

  // Convert the held sample for the FIFO, clamping out-of-range samples when enabled.
  always_comb begin
    w_wr_data = f_to_twos(r_sample);
`ifdef AD9226IF_OTR_SAT_EN
    if (r_sample_otr) begin
      w_wr_data = f_saturate(r_sample);
    end else begin
      w_wr_data = f_to_twos(r_sample);
    end
`else
    if (r_sample_otr) begin
      w_wr_data = f_to_twos(r_sample);
    end else begin
      w_wr_data = f_to_twos(r_sample);
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  assign w_full    = (r_cnt == FULL_CNT);
  assign w_pop     = o_valid && i_ready;
  // A write to a full FIFO still lands when the head leaves on the same edge.
  assign w_wr_acc  = r_wr_pend && (!w_full || w_pop);
  assign w_wr_drop = r_wr_pend && w_full && !w_pop;

  // Storage; cleared on reset so the head reads zero while empty.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= 12'd0;
        r_mem_last[i] <= 1'b0;
      end
    end else if (w_wr_acc) begin
      r_mem_data[r_wr_ptr] <= w_wr_data;
      r_mem_last[r_wr_ptr] <= r_wr_last;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_acc, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Sticky drop flag; a drop on the same edge as a new start still registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
    end else if (w_wr_drop) begin
      r_overflow <= 1'b1;
    end else if (w_clr) begin
      r_overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all taken straight from registers)
  // ---------------------------------------------------------------------------
  assign o_adc_clk  = r_adc_clk;
  assign o_busy     = (r_state != S_IDLE);
  assign o_valid    = (r_cnt != {CW{1'b0}});
  assign o_data     = r_mem_data[r_rd_ptr];
  assign o_last     = r_mem_last[r_rd_ptr];
  assign o_overflow = r_overflow;
  assign o_otr      = r_otr;

endmodule

// File: tb/tb_ad9226if.sv
// tb_ad9226if: scoreboard bench for ad9226if with default parameters.
// An ADC model drives the bus on each rising o_adc_clk and, while a capture is
// armed, pushes the expected converted sample for each FILL capture; a monitor
// pops and compares on every accepted transfer.
`timescale 1ns/1ps

module tb_ad9226if;

  localparam int CLK_DIV    = 4;
  localparam int PIPE_LAT   = 7;
  localparam int BLOCK_LEN  = 16;
  localparam int FIFO_DEPTH = 4;

`ifdef AD9226IF_OTR_SAT_EN
  localparam bit          SAT_EN  = 1'b1;
  localparam logic [11:0] OTR_EXP = 12'h7FF;
`else
  localparam bit          SAT_EN  = 1'b0;
  localparam logic [11:0] OTR_EXP = 12'h700;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_adc_clk;
  logic [11:0] i_adc_data = 12'h800;
  logic        i_adc_otr = 1'b0;
  logic        i_start = 1'b0;
  logic        o_busy;
  logic [11:0] o_data;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic        o_last;
  logic        o_overflow;
  logic        o_otr;

  ad9226if #(
    .CLK_DIV(CLK_DIV), .PIPE_LAT(PIPE_LAT), .BLOCK_LEN(BLOCK_LEN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .o_adc_clk(o_adc_clk), .i_adc_data(i_adc_data),
    .i_adc_otr(i_adc_otr), .i_start(i_start), .o_busy(o_busy), .o_data(o_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last), .o_overflow(o_overflow),
    .o_otr(o_otr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        last;
    logic [11:0] data;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  bit          armed = 1'b0;
  bit          block_done = 1'b0;
  bit          exp_ovf = 1'b0;
  bit          exp_otr = 1'b0;
  int          disc = 0;
  int          fill = 0;
  int          n_xfer = 0;
  int          n_last = 0;
  logic [11:0] first_data = 12'd0;
  bit          cfg_ramp = 1'b0;
  logic [11:0] cfg_val = 12'h800;
  bit          cfg_otr = 1'b0;
  int          load_seq = 0;
  int          load_seen = 0;
  logic [11:0] m_raw;
  logic        m_otr;
  exp_t        m_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_conv(input logic [11:0] raw, input logic otr);
    logic [11:0] v;
    v = {~raw[11], raw[10:0]};
    if (otr && SAT_EN) v = raw[11] ? 12'h7FF : 12'h800;
    return v;
  endfunction

  task automatic outs_zero(input string pfx);
    chk({pfx, "_adc_clk"}, 32'(o_adc_clk), 32'd0);
    chk({pfx, "_valid"}, 32'(o_valid), 32'd0);
    chk({pfx, "_data"}, 32'(o_data), 32'd0);
    chk({pfx, "_last"}, 32'(o_last), 32'd0);
    chk({pfx, "_busy"}, 32'(o_busy), 32'd0);
    chk({pfx, "_overflow"}, 32'(o_overflow), 32'd0);
    chk({pfx, "_otr"}, 32'(o_otr), 32'd0);
  endtask

  task automatic set_ready(input logic v);
    @(posedge i_clk);
    #1 i_ready = v;
  endtask

  // Program the ADC model; the new value appears at the next o_adc_clk rise.
  task automatic adc_cfg(input bit ramp, input logic [11:0] val, input bit otr);
    cfg_ramp = ramp;
    cfg_val  = val;
    cfg_otr  = otr;
    load_seq++;
    for (int i = 0; i < 40 && load_seen != load_seq; i++) @(negedge i_clk);
    if (load_seen != load_seq) chk("adc_cfg_timeout", 32'(load_seen), 32'(load_seq));
  endtask

  task automatic start_block(input string tag);
    @(posedge i_clk);
    #1 i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    armed = 1'b1; disc = 0; fill = 0; block_done = 1'b0;
    exp_ovf = 1'b0; exp_otr = 1'b0; n_xfer = 0; n_last = 0;
    @(negedge i_clk);
    chk({tag, "_busy_on"}, 32'(o_busy), 32'd1);
    chk({tag, "_ovf_clr"}, 32'(o_overflow), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400 && !block_done; i++) @(negedge i_clk);
    if (!block_done) chk({tag, "_done_timeout"}, 32'(block_done), 32'd1);
    chk({tag, "_busy_off"}, 32'(o_busy), 32'd0);
    @(negedge i_clk);
    chk({tag, "_overflow"}, 32'(o_overflow), 32'(exp_ovf));
    chk({tag, "_otr"}, 32'(o_otr), 32'(exp_otr));
  endtask

  task automatic wait_drain(input string tag, input int xfers, input int lasts);
    for (int i = 0; i < 60 && (sb.size() != 0 || o_valid); i++) @(negedge i_clk);
    chk({tag, "_pending"}, 32'(sb.size()), 32'd0);
    chk({tag, "_valid_off"}, 32'(o_valid), 32'd0);
    chk({tag, "_xfers"}, 32'(n_xfer), 32'(xfers));
    chk({tag, "_lasts"}, 32'(n_last), 32'(lasts));
  endtask

  initial begin
    fork
      // ADC model and expected-sample generator.
      forever begin
        @(posedge o_adc_clk);
        m_raw = i_adc_data;
        m_otr = i_adc_otr;
        if (armed) begin
          if (disc < PIPE_LAT) begin
            disc++;
          end else begin
            m_e.last = (fill == BLOCK_LEN - 1);
            m_e.data = exp_conv(m_raw, m_otr);
            if (m_otr) exp_otr = 1'b1;
            if (!i_ready && sb.size() >= FIFO_DEPTH) exp_ovf = 1'b1;
            else sb.push_back(m_e);
            fill++;
            if (m_e.last) begin
              armed = 1'b0;
              block_done = 1'b1;
            end
          end
        end
        if (load_seen != load_seq) begin
          i_adc_data = cfg_val;
          i_adc_otr  = cfg_otr;
          load_seen  = load_seq;
        end else if (cfg_ramp) begin
          i_adc_data = i_adc_data + 12'd1;
        end
      end
      // Output monitor: compare every accepted transfer against the scoreboard.
      forever begin
        @(negedge i_clk);
        if (!i_rst && o_valid && i_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", 32'(o_valid), 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("data", 32'(o_data), 32'(e.data));
            chk("last", 32'(o_last), 32'(e.last));
          end
          if (n_xfer == 0) first_data = o_data;
          n_xfer++;
          if (o_last) n_last++;
        end
      end
    join_none

    // Reset values and free-running sample clock.
    #1 outs_zero("rst");
    @(posedge i_clk);
    @(posedge i_clk);
    @(negedge i_clk);
    #1 i_rst = 1'b0;
    outs_zero("rel");
    for (int k = 1; k <= 20; k++) begin
      @(negedge i_clk);
      chk($sformatf("adc_clk_e%0d", k), 32'(o_adc_clk),
          32'((k >= CLK_DIV) && (((k - CLK_DIV) % (2 * CLK_DIV)) < CLK_DIV)));
    end

    // Ramp block with a free-flowing consumer.
    set_ready(1'b1);
    adc_cfg(1'b1, 12'h800, 1'b0);
    start_block("ramp");
    wait_done("ramp");
    wait_drain("ramp", BLOCK_LEN, 1);

    // Format conversion corner values.
    adc_cfg(1'b0, 12'h800, 1'b0);
    start_block("cv800");
    wait_done("cv800");
    wait_drain("cv800", BLOCK_LEN, 1);
    chk("conv_800", 32'(first_data), 32'h000);
    adc_cfg(1'b0, 12'hFFF, 1'b0);
    start_block("cvfff");
    wait_done("cvfff");
    wait_drain("cvfff", BLOCK_LEN, 1);
    chk("conv_fff", 32'(first_data), 32'h7FF);
    adc_cfg(1'b0, 12'h000, 1'b0);
    start_block("cv000");
    wait_done("cv000");
    wait_drain("cv000", BLOCK_LEN, 1);
    chk("conv_000", 32'(first_data), 32'h800);

    // Stalled consumer: FIFO fills, rest dropped, no last delivered.
    set_ready(1'b0);
    adc_cfg(1'b1, 12'h100, 1'b0);
    start_block("ovf");
    wait_done("ovf");
    chk("ovf_sticky", 32'(o_overflow), 32'd1);
    chk("ovf_held", 32'(o_valid), 32'd1);
    set_ready(1'b1);
    wait_drain("ovf", FIFO_DEPTH, 0);
    start_block("ovf2");
    wait_done("ovf2");
    wait_drain("ovf2", BLOCK_LEN, 1);

    // Out-of-range samples during FILL.
    adc_cfg(1'b0, 12'hF00, 1'b1);
    start_block("otr");
    wait_done("otr");
    chk("otr_sticky", 32'(o_otr), 32'd1);
    wait_drain("otr", BLOCK_LEN, 1);
    chk("otr_data", 32'(first_data), 32'(OTR_EXP));

    // Asynchronous reset in the middle of FILL with two entries queued.
    set_ready(1'b0);
    adc_cfg(1'b1, 12'h400, 1'b0);
    start_block("mid");
    for (int i = 0; i < 400 && fill < 2; i++) @(negedge i_clk);
    chk("mid_fill_reached", 32'(fill >= 2), 32'd1);
    @(negedge i_clk);
    @(negedge i_clk);
    chk("mid_queued", 32'(o_valid), 32'd1);
    #2 i_rst = 1'b1;
    #1 outs_zero("arst");
    armed = 1'b0;
    sb.delete();
    @(posedge i_clk);
    @(posedge i_clk);
    @(negedge i_clk);
    #1 i_rst = 1'b0;
    i_ready = 1'b1;
    start_block("fresh");
    wait_done("fresh");
    wait_drain("fresh", BLOCK_LEN, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
